alu_issue: RTL

// - Issue stage directly upstream of combinational `alu`: buffers requests (A, B, ALUOp) in a FIFO.
// - Presents the FIFO head to an `alu` instance and registers C into a valid/ready output stage.
// - Lets a sequential producer (controller, testbench driver) stream ALU ops with back-pressure, one result per cycle.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 25 ++
 rtl/alu_req_fifo.sv | 62 ++++++
 rtl/alu_issue.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the request record held in the
// issue FIFO. When ALU_FWD_EN is defined the record also carries the two
// operand-forwarding flags.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  typedef struct packed {
`ifdef ALU_FWD_EN
    logic             a_fwd;
    logic             b_fwd;
`endif
    logic [2:0]       op;
    logic [ALU_W-1:0] b;
    logic [ALU_W-1:0] a;
  } alu_req_t;

  localparam int ALU_REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Codes 110/111 produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C
);

  // Opcode decode; shift amount is the low five bits of B
  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD: C = A + B;
      ALU_SUB: C = A - B;
      ALU_AND: C = A & B;
      ALU_OR:  C = A | B;
      ALU_SRL: C = A >> B[4:0];
      ALU_SRA: C = $unsigned($signed(A) >>> B[4:0]);
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_fifo.sv
// DEPTH-entry synchronous FIFO for ALU requests. Pushes while full are
// dropped even if a pop happens the same cycle; pops while empty are ignored.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Occupancy: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: queues requests, feeds the FIFO head to the ALU and
// registers the result into a valid/ready output stage, one op per cycle.
// Optional feature macro: ALU_FWD_EN (operands may take the last issued result).
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  input  logic         in_a_fwd,
  input  logic         in_b_fwd,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic         out_zero,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH+1);

  alu_req_t             req_in, head;
  logic [ALU_REQ_W-1:0] head_bits;
  logic                 full, empty, issue;
  logic [CW-1:0]        count;
  logic [W-1:0]         alu_a, alu_b, alu_c;

  logic         out_valid_q, out_zero_q;
  logic [W-1:0] out_c_q, last_c_q;

  // Pack the incoming request; forward flags only exist when enabled
  always_comb begin
    req_in    = '0;
    req_in.a  = in_a;
    req_in.b  = in_b;
    req_in.op = in_op;
`ifdef ALU_FWD_EN
    req_in.a_fwd = in_a_fwd;
    req_in.b_fwd = in_b_fwd;
`endif
  end

`ifndef ALU_FWD_EN
  logic unused_fwd;
  assign unused_fwd = in_a_fwd ^ in_b_fwd;
`endif

  alu_req_fifo #(.DEPTH(DEPTH), .WIDTH(ALU_REQ_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .data_i  (req_in),
    .pop_i   (issue),
    .data_o  (head_bits),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head  = alu_req_t'(head_bits);
  assign issue = ~empty & (~out_valid_q | out_ready);

  // Operand select; forwarding is resolved against the last issued result
  always_comb begin
    alu_a = head.a;
    alu_b = head.b;
`ifdef ALU_FWD_EN
    if (head.a_fwd) alu_a = last_c_q;
    if (head.b_fwd) alu_b = last_c_q;
`endif
  end

  alu u_alu (
    .A     (alu_a),
    .B     (alu_b),
    .ALUOp (head.op),
    .C     (alu_c)
  );

  // Output stage: load on issue, clear valid on drain, keep data otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_zero_q  <= 1'b0;
      last_c_q    <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_c_q     <= alu_c;
      out_zero_q  <= (alu_c == '0);
      last_c_q    <= alu_c;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  logic unused_count;
  assign unused_count = ^count;

  assign in_ready  = ~full;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_zero  = out_zero_q;
  assign busy      = ~empty | out_valid_q;

endmodule
